// File: rtl/fft_magni_frame_reader.sv
// Captures one frame of FFT magnitude samples into a local RAM, then replays it to the
// UART TX as SYNC0, SYNC1, MSB/LSB byte pairs per bin and a trailing XOR checksum.
module fft_magni_frame_reader #(
    parameter int          ADDR_W = 14,
    parameter int          N_OUT  = 8192,
    parameter logic [7:0]  SYNC0  = 8'hA5,
    parameter logic [7:0]  SYNC1  = 8'h5A
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        s_magni_valid,
    input  logic [15:0] s_magni_data,
    input  logic [15:0] s_magni_addr,
    output logic [7:0]  m_tx_data,
    output logic        m_tx_valid,
    input  logic        m_tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        err_seq
);

    localparam int AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int SEQ_W = $clog2(2 * N_OUT + 4);
    localparam logic [SEQ_W-1:0] SEQ_CHK  = SEQ_W'(2 * N_OUT + 2);
    localparam logic [SEQ_W-1:0] SEQ_END  = SEQ_W'(2 * N_OUT + 3);
    localparam logic [AW-1:0]    EXP_LAST = AW'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [15:0]        r_mem [N_OUT];
    logic [15:0]        r_rd_q;
    logic [7:0]         r_lsb;
    logic [AW-1:0]      r_rd_addr;
    logic [AW-1:0]      r_exp;
    logic [7:0]         r_chk;
    logic [SEQ_W-1:0]   r_seq;

    logic [ADDR_W-1:0]  w_idx;
    logic [AW-1:0]      w_idx_lo;
    logic               w_in_range;
    logic               w_arm_hit;
    logic               w_cap_ok;
    logic               w_cap_err;
    logic               w_wr_en;
    logic               w_load;
    logic               w_msb_load;
    logic               w_last_acc;
    logic [7:0]         w_byte;
    logic [7:0]         w_pair_xor;
    logic               w_unused;

    assign w_unused   = &{1'b0, s_magni_addr};
    assign w_idx      = s_magni_addr[ADDR_W-1:0];
    assign w_idx_lo   = w_idx[AW-1:0];
    assign w_in_range = ({1'b0, w_idx} < (ADDR_W + 1)'(N_OUT));
    assign w_pair_xor = s_magni_data[15:8] ^ s_magni_data[7:0];

    assign w_arm_hit  = s_magni_valid && (w_idx == '0);
    assign w_cap_ok   = s_magni_valid && w_in_range && (w_idx_lo == r_exp);
    assign w_cap_err  = s_magni_valid && w_in_range && (w_idx_lo != r_exp);
    assign w_wr_en    = ((r_state == S_ARM) && w_arm_hit) ||
                        ((r_state == S_CAPTURE) && w_cap_ok);

    // Output register refills whenever it is empty or its byte is leaving this cycle
    assign w_load     = (r_state == S_SEND) && (!m_tx_valid || m_tx_ready) && (r_seq != SEQ_END);
    assign w_last_acc = (r_state == S_SEND) && m_tx_valid && m_tx_ready && (r_seq == SEQ_END);
    assign w_msb_load = w_load && (r_seq >= SEQ_W'(2)) && (r_seq != SEQ_CHK) && !r_seq[0];

    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_ARM;
            S_ARM:     if (w_arm_hit) w_next = (N_OUT == 1) ? S_SEND : S_CAPTURE;
            S_CAPTURE: begin
                if (w_cap_ok && (r_exp == EXP_LAST)) begin
                    w_next = S_SEND;
                end else if (w_cap_err) begin
                    w_next = S_ARM;
                end
            end
            S_SEND:    if (w_last_acc) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Byte sequence: 0 -> SYNC0, 1 -> SYNC1, even body index -> MSB, odd -> LSB, last -> checksum
    always_comb begin
        w_byte = r_chk;
        if (r_seq == SEQ_W'(0)) begin
            w_byte = SYNC0;
        end else if (r_seq == SEQ_W'(1)) begin
            w_byte = SYNC1;
        end else if (r_seq == SEQ_CHK) begin
            w_byte = r_chk;
        end else if (!r_seq[0]) begin
            w_byte = r_rd_q[15:8];
        end else begin
            w_byte = r_lsb;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_tx_data  <= '0;
            m_tx_valid <= 1'b0;
            err_seq    <= 1'b0;
            r_exp      <= '0;
            r_chk      <= '0;
            r_seq      <= '0;
            r_rd_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) err_seq <= 1'b0;
                end
                S_ARM: begin
                    r_seq     <= '0;
                    r_rd_addr <= '0;
                    if (w_arm_hit) begin
                        r_exp <= AW'(1);
                        r_chk <= w_pair_xor;
                    end
                end
                S_CAPTURE: begin
                    if (w_cap_ok) begin
                        r_exp <= r_exp + AW'(1);
                        r_chk <= r_chk ^ w_pair_xor;
                    end else if (w_cap_err) begin
                        err_seq <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_load) begin
                        m_tx_data  <= w_byte;
                        m_tx_valid <= 1'b1;
                        r_seq      <= r_seq + SEQ_W'(1);
                        if (w_msb_load) r_rd_addr <= r_rd_addr + AW'(1);
                    end else if (w_last_acc) begin
                        m_tx_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM read runs every cycle so the next bin is already on r_rd_q when its MSB is due
    always_ff @(posedge sys_clk) begin
        if (w_wr_en) r_mem[w_idx_lo] <= s_magni_data;
        r_rd_q <= r_mem[r_rd_addr];
        if (w_msb_load) r_lsb <= r_rd_q[7:0];
    end

endmodule

// File: tb/tb_fft_magni_frame_reader.sv
// Bench for fft_magni_frame_reader: a small 4-bin instance for protocol scenarios and a
// default-size instance for the full 16384-bin frame.
module tb_fft_magni_frame_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0, vld = 1'b0, tx_ready = 1'b1;
    logic [15:0] data = '0, addr = '0;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, fdone, err;

    logic        b_start = 1'b0, b_vld = 1'b0, b_ready = 1'b1;
    logic [15:0] b_data = '0, b_addr = '0;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid, b_busy, b_fdone, b_err;

    int          n_chk = 0, n_pass = 0;
    int          fd_cnt = 0, b_fd_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  b_q[$];
    bit          stall = 0;
    logic [7:0]  stall_data = '0;

    always #5 clk = ~clk;

    fft_magni_frame_reader #(.ADDR_W(4), .N_OUT(4)) u_small (
        .sys_clk(clk), .sys_rst(rst), .start(start),
        .s_magni_valid(vld), .s_magni_data(data), .s_magni_addr(addr),
        .m_tx_data(tx_data), .m_tx_valid(tx_valid), .m_tx_ready(tx_ready),
        .busy(busy), .frame_done(fdone), .err_seq(err)
    );

    fft_magni_frame_reader u_big (
        .sys_clk(clk), .sys_rst(rst), .start(b_start),
        .s_magni_valid(b_vld), .s_magni_data(b_data), .s_magni_addr(b_addr),
        .m_tx_data(b_tx_data), .m_tx_valid(b_tx_valid), .m_tx_ready(b_ready),
        .busy(b_busy), .frame_done(b_fdone), .err_seq(b_err)
    );

    // Scoreboard for the small instance: accepted bytes against the queue, plus hold-while-stalled
    always @(negedge clk) begin
        if (rst) begin
            stall = 0;
        end else begin
            if (stall) begin
                n_chk++;
                if (tx_valid !== 1'b1 || tx_data !== stall_data)
                    $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", tx_valid, tx_data, stall_data);
                else n_pass++;
            end
            if (tx_valid && tx_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL byte: got %h with nothing expected", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) $display("FAIL byte: got %h required %h", tx_data, e);
                    else n_pass++;
                end
            end
            stall      = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (fdone) fd_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_tx_valid && b_ready) begin
                n_chk++;
                if (b_q.size() == 0) begin
                    $display("FAIL big_byte: got %h with nothing expected", b_tx_data);
                end else begin
                    logic [7:0] e;
                    e = b_q.pop_front();
                    if (b_tx_data !== e) $display("FAIL big_byte: got %h required %h", b_tx_data, e);
                    else n_pass++;
                end
            end
            if (b_fdone) b_fd_cnt++;
        end
    end

    task automatic push_small(input logic [15:0] base);
        logic [7:0]  c;
        logic [15:0] d;
        c = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int k = 0; k < 4; k++) begin
            d = base + 16'(k);
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
            c = c ^ d[15:8] ^ d[7:0];
        end
        exp_q.push_back(c);
    endtask

    task automatic stream(input int first, input int n, input logic [15:0] base, input int start_addr);
        bit fired;
        fired = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            addr  = 16'((first + i) % 16);
            data  = base + addr;
            vld   = 1'b1;
            start = (!fired && (int'(addr) == start_addr));
            if (start) fired = 1;
        end
        @(posedge clk); #1;
        vld   = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int fd0, input int limit, input bit rnd, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (fd_cnt != fd0) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) tx_ready = ($urandom_range(0, 9) < 3);
        end
        if (fd_cnt != fd0) ok = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %h required 00", tx_data); else n_pass++;
        n_chk++; if (tx_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", tx_valid); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
        n_chk++; if (fdone !== 1'b0) $display("FAIL rst_done: got %b required 0", fdone); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL rst_err: got %b required 0", err); else n_pass++;
        n_chk++; if (b_tx_valid !== 1'b0 || b_busy !== 1'b0) $display("FAIL rst_big: valid=%b busy=%b required 0 0", b_tx_valid, b_busy); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int fd0; bit ok;
        tx_ready = 1'b1;
        fd0 = fd_cnt;
        push_small(16'h0100);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_chk++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy); else n_pass++;
        stream(0, 16, 16'h0100, -1);
        wait_done(fd0, 100, 0, ok);
        n_chk++; if (!ok) $display("FAIL basic_timeout: frame_done count %0d required %0d", fd_cnt - fd0, 1); else n_pass++;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (fd_cnt - fd0 !== 1) $display("FAIL basic_done_pulses: got %0d required 1", fd_cnt - fd0); else n_pass++;
        n_chk++; if (exp_q.size() !== 0) $display("FAIL basic_left: got %0d bytes unsent required 0", exp_q.size()); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL basic_err: got %b required 0", err); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL basic_idle: busy %b required 0", busy); else n_pass++;
    endtask

    task automatic test_arm_align();
        int fd0; bit ok;
        tx_ready = 1'b1;
        fd0 = fd_cnt;
        push_small(16'h0100);
        stream(5, 27, 16'h0100, 7);
        wait_done(fd0, 100, 0, ok);
        repeat (3) @(posedge clk); #1;
        n_chk++; if (!ok || fd_cnt - fd0 !== 1) $display("FAIL arm_done: got %0d pulses required 1", fd_cnt - fd0); else n_pass++;
        n_chk++; if (exp_q.size() !== 0) $display("FAIL arm_left: got %0d bytes unsent required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        int fd0; bit ok;
        tx_ready = 1'b0;
        fd0 = fd_cnt;
        push_small(16'h3C71);
        pulse_start();
        stream(0, 16, 16'h3C71, -1);
        wait_done(fd0, 400, 1, ok);
        tx_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (!ok || fd_cnt - fd0 !== 1) $display("FAIL bp_done: got %0d pulses required 1", fd_cnt - fd0); else n_pass++;
        n_chk++; if (exp_q.size() !== 0) $display("FAIL bp_left: got %0d bytes unsent required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_seq_error();
        int fd0; bit ok;
        tx_ready = 1'b1;
        pulse_start();
        stream(0, 2, 16'h0100, -1);
        stream(3, 1, 16'h0100, -1);
        @(negedge clk);
        n_chk++; if (err !== 1'b1) $display("FAIL seq_err_set: got %b required 1", err); else n_pass++;
        n_chk++; if (busy !== 1'b1 || tx_valid !== 1'b0) $display("FAIL seq_rearm: busy=%b valid=%b required 1 0", busy, tx_valid); else n_pass++;
        fd0 = fd_cnt;
        push_small(16'h0100);
        stream(0, 4, 16'h0100, -1);
        wait_done(fd0, 100, 0, ok);
        repeat (3) @(posedge clk); #1;
        n_chk++; if (!ok || fd_cnt - fd0 !== 1) $display("FAIL seq_done: got %0d pulses required 1", fd_cnt - fd0); else n_pass++;
        n_chk++; if (exp_q.size() !== 0) $display("FAIL seq_left: got %0d bytes unsent required 0", exp_q.size()); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL seq_err_sticky: got %b required 1", err); else n_pass++;
        pulse_start();
        n_chk++; if (err !== 1'b0) $display("FAIL seq_err_clear: got %b required 0", err); else n_pass++;
        fd0 = fd_cnt;
        push_small(16'h0100);
        stream(0, 4, 16'h0100, -1);
        wait_done(fd0, 100, 0, ok);
        repeat (3) @(posedge clk); #1;
        n_chk++; if (!ok || exp_q.size() !== 0) $display("FAIL seq_frame2: got %0d bytes unsent required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        int fd0; bit seen; bit ok;
        tx_ready = 1'b0;
        push_small(16'hBEE0);
        pulse_start();
        stream(0, 4, 16'hBEE0, -1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid) seen = 1;
        end
        n_chk++; if (!seen) $display("FAIL rms_valid: got valid 0 required 1"); else n_pass++;
        @(posedge clk); #1 tx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 tx_ready = 1'b0;
        n_chk++; if (exp_q.size() !== 6) $display("FAIL rms_accepted: got %0d left required 6", exp_q.size()); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_chk++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL rms_async: valid=%b data=%h required 0 00", tx_valid, tx_data); else n_pass++;
        n_chk++; if (busy !== 1'b0 || fdone !== 1'b0 || err !== 1'b0) $display("FAIL rms_flags: busy=%b done=%b err=%b required 0 0 0", busy, fdone, err); else n_pass++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tx_ready = 1'b1;
        fd0 = fd_cnt;
        push_small(16'hBEE0);
        pulse_start();
        stream(0, 4, 16'hBEE0, -1);
        wait_done(fd0, 100, 0, ok);
        repeat (3) @(posedge clk); #1;
        n_chk++; if (!ok || exp_q.size() !== 0) $display("FAIL rms_frame: got %0d bytes unsent required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_full_size();
        logic [7:0]  c;
        logic [15:0] d;
        int          fd0;
        bit          ok;
        c = 8'h00;
        b_q.push_back(8'hA5);
        b_q.push_back(8'h5A);
        for (int k = 0; k < 8192; k++) begin
            d = 16'(k);
            b_q.push_back(d[15:8]);
            b_q.push_back(d[7:0]);
            c = c ^ d[15:8] ^ d[7:0];
        end
        b_q.push_back(c);
        fd0 = b_fd_cnt;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int i = 0; i < 16384; i++) begin
            @(posedge clk); #1;
            b_vld   = 1'b1;
            b_addr  = 16'(i);
            b_data  = 16'(i);
            b_start = (i == 12000);
        end
        @(posedge clk); #1;
        b_vld   = 1'b0;
        b_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(posedge clk); #1;
            if (b_fd_cnt != fd0) ok = 1;
        end
        repeat (3) @(posedge clk); #1;
        n_chk++; if (!ok || b_fd_cnt - fd0 !== 1) $display("FAIL full_done: got %0d pulses required 1", b_fd_cnt - fd0); else n_pass++;
        n_chk++; if (b_q.size() !== 0) $display("FAIL full_left: got %0d bytes unsent required 0", b_q.size()); else n_pass++;
        n_chk++; if (b_busy !== 1'b0) $display("FAIL full_start_ignored: busy %b required 0", b_busy); else n_pass++;
        n_chk++; if (b_err !== 1'b0) $display("FAIL full_err: got %b required 0", b_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arm_align();
        test_backpressure();
        test_seq_error();
        test_reset_mid_send();
        test_full_size();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_magni_frame_reader.md
# fft_magni_frame_reader

Consumer end of the FFT magnitude stream: arms on request, captures one frame of magnitude samples (valid/data/addr) into an internal RAM, then replays it as a framed byte stream toward the UART transmitter. Sits between the FFT magnitude block and the UART TX, decoupling the full-rate FFT output from the slow serial link.

## Interface
- ADDR_W, 14: FFT point-index width in use (16384-point FFT); upper addr bits ignored.
- N_OUT, 8192: samples captured and sent (addr 0..N_OUT-1; first half of spectrum). Power of two, ≤ 2^ADDR_W.
- SYNC0, 8'hA5: first header byte.
- SYNC1, 8'h5A: second header byte.

- sys_clk  in  1  system clock (50 MHz).
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  capture request pulse; honoured only in IDLE.
- s_magni_valid  in  1  magnitude sample valid (no backpressure possible).
- s_magni_data  in  16  magnitude value.
- s_magni_addr  in  16  frequency-bin index of s_magni_data.
- m_tx_data  out  8  byte to UART TX.
- m_tx_valid  out  1  byte valid; held until accepted.
- m_tx_ready  in  1  UART TX ready; byte transfers when valid && ready.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after trailer byte accepted.
- err_seq  out  1  sticky: out-of-order address seen during capture; cleared by start.

## Operation
- States: IDLE, ARM, CAPTURE, SEND, DONE.
- IDLE: start=1 → ARM; err_seq cleared same edge. start in any other state ignored.
- ARM: wait for s_magni_valid with addr[ADDR_W-1:0]==0; that sample written to RAM[0], expected index ← 1, → CAPTURE. Other samples discarded.
- CAPTURE: per valid sample, idx = addr[ADDR_W-1:0]:
  - idx ≥ N_OUT: ignored.
  - idx == expected: RAM[idx] ← data, expected+1; if idx == N_OUT-1 → SEND.
  - otherwise: err_seq ← 1, nothing written, → ARM (sample with idx 0 re-arms in ARM on a later cycle, not this one).
- SEND byte order: SYNC0, SYNC1, then for k = 0..N_OUT-1: data[k][15:8], data[k][7:0], then checksum = XOR of all 2·N_OUT data bytes (headers excluded). Total 2·N_OUT+3 bytes.
- RAM: N_OUT×16, one write port, synchronous read, 1-cycle latency; reader prefetches so no bubble beyond those stated in Timing.
- DONE: one cycle, frame_done=1, → IDLE.
- Input stream ignored in SEND/DONE/IDLE (RAM not written).

## Timing
- Reset values: m_tx_data=0, m_tx_valid=0, busy=0, frame_done=0, err_seq=0, state IDLE, counters/checksum 0. Reset mid-operation aborts immediately; no partial byte resumes.
- start sampled at edge t → state ARM and busy=1 from t+1.
- Capture writes on the same edge the valid sample is sampled; no input latency.
- Last sample (N_OUT-1) written at edge t → SEND at t+1; m_tx_valid=1 with SYNC0 no later than t+2.
- AXI-style handshake: once m_tx_valid=1, m_tx_data stable and valid not deasserted until valid&&ready. With m_tx_ready held 1, one byte per cycle, no gaps (including MSB/LSB boundary and sample-to-sample transitions).
- Trailer accepted at edge t → m_tx_valid=0 at t+1, frame_done=1 for cycle t+1 only (DONE), busy=0 from t+2.
- start in the DONE cycle ignored; start one cycle later accepted.

## Test plan
- Basic frame (N_OUT=4, ADDR_W=4): start; feed addr 0..15 with data 0x0100+addr, ready=1 → bytes A5 5A 01 00 01 01 01 02 01 03 chk=0x00, frame_done pulse once, err_seq=0.
- Arm alignment: start while stream at addr 7 → samples 7..15 dropped; capture begins at next addr 0; output identical to basic frame.
- Backpressure: m_tx_ready random 30% duty → same 11-byte sequence, m_tx_data never changes while valid && !ready, no duplicates/drops.
- Sequence error: feed 0,1,3 → err_seq=1, state ARM; next clean 0..3 frame sent correctly, err_seq stays 1 until next start.
- Reset mid-SEND after 5 bytes accepted: all outputs return to reset values asynchronously; new start + frame yields full correct sequence from A5.
- Full size (defaults): 16384-bin stream, data = bin index low 16 bits → 16387 bytes, checksum matches model, start during SEND has no effect.
